// File: rtl/rx_unstuff_shift_if.sv
// rx_unstuff_shift_if: bus between the NRZI decoder side and the bit
// unstuffer / word assembler.
//   d_original    decoded bit, valid while shift_enable=1
//   shift_enable  one-cycle strobe per received bit period
//   eop           end-of-packet, clears word framing
//   rx_data       assembled word, LSB = first bit received
//   byte_received one-cycle pulse, rx_data holds a complete word
//   partial_byte  one-cycle pulse, eop arrived mid-word
//   stuff_error   sticky stuff-violation flag
// master: drives the bit stream and observes results.
// slave:  the unstuffer.
interface rx_unstuff_shift_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  d_original;
  logic                  shift_enable;
  logic                  eop;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  byte_received;
  logic                  partial_byte;
  logic                  stuff_error;

  modport master (
    output d_original, shift_enable, eop,
    input  rx_data, byte_received, partial_byte, stuff_error
  );

  modport slave (
    input  d_original, shift_enable, eop,
    output rx_data, byte_received, partial_byte, stuff_error
  );
endinterface

// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift: removes USB stuffed zeros from the NRZI-decoded bit
// stream and assembles the remaining bits LSB-first into words.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rx_unstuff_shift_if.slave (d_original, shift_enable, eop in;
//        rx_data, byte_received, partial_byte, stuff_error out)
// Optional feature: define RX_STUFF_ERR_EN to flag a 1 in the stuff slot
// on stuff_error (sticky until eop/rst). Without it stuff_error is tied
// low and the stuff counter silently resynchronises.
module rx_unstuff_shift #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_RUN  = 6
) (
  input logic             clk,
  input logic             rst,
  rx_unstuff_shift_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int OW = $clog2(STUFF_RUN + 1);

  logic [CW-1:0]         bit_cnt;
  logic [OW-1:0]         ones_cnt;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  byte_received;
  logic                  partial_byte;
  logic                  stuff_slot;

  assign stuff_slot = (ones_cnt == OW'(STUFF_RUN));

`ifdef RX_STUFF_ERR_EN
  logic stuff_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_error <= 1'b0;
    end else if (bus.eop) begin
      stuff_error <= 1'b0;
    end else if (bus.shift_enable && stuff_slot && bus.d_original) begin
      stuff_error <= 1'b1;
    end
  end
`else
  logic stuff_error;
  assign stuff_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      byte_received <= 1'b0;
      partial_byte  <= 1'b0;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
    end else begin
      byte_received <= 1'b0;
      partial_byte  <= 1'b0;
      if (bus.eop) begin
        partial_byte <= (bit_cnt != '0);
        bit_cnt      <= '0;
        ones_cnt     <= '0;
      end else if (bus.shift_enable) begin
        if (stuff_slot) begin
          // Stuff slot: sample is never shifted in. A 1 here is a violation;
          // with error reporting the counter stays saturated so further 1s
          // are also dropped until a 0 re-aligns the stream.
`ifdef RX_STUFF_ERR_EN
          if (!bus.d_original) ones_cnt <= '0;
`else
          ones_cnt <= '0;
`endif
        end else begin
          rx_data  <= {bus.d_original, rx_data[DATA_WIDTH-1:1]};
          ones_cnt <= bus.d_original ? ones_cnt + OW'(1) : '0;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            bit_cnt       <= '0;
            byte_received <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign bus.rx_data       = rx_data;
  assign bus.byte_received = byte_received;
  assign bus.partial_byte  = partial_byte;
  assign bus.stuff_error   = stuff_error;

endmodule

// File: doc/rx_unstuff_shift.md
Name: rx_unstuff_shift

Overview:
- Downstream of the NRZI decoder in the USB receive path.
- Consumes the decoded bit stream (d_original) on each shift_enable strobe and removes stuffed zeros (the zero inserted after STUFF_RUN consecutive ones).
- Assembles the remaining bits LSB-first into DATA_WIDTH-bit words and pulses byte_received for the RX controller/FIFO.
- Flags bit-stuff violations and packets that end on a partial word.

Parameters:
- DATA_WIDTH, 8, bits per assembled word.
- STUFF_RUN, 6, consecutive ones after which the next sample is a stuff bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- d_original  input  1  NRZI-decoded bit, valid when shift_enable=1.
- shift_enable  input  1  one-cycle strobe per received bit period.
- eop  input  1  end-of-packet; synchronous clear of word framing.
- rx_data  output  DATA_WIDTH  assembled word; LSB is the first bit received.
- byte_received  output  1  one-cycle pulse; rx_data holds a complete word.
- partial_byte  output  1  one-cycle pulse; eop arrived with bit_cnt != 0.
- stuff_error  output  1  sticky flag for a stuff violation (see Optional Feature).

Behaviour:
- Reset: one clock; rst is synchronous and active-high. While rst=1 at a clk edge:
  - rx_data=0, byte_received=0, partial_byte=0, stuff_error=0.
  - Internal bit_cnt=0, ones_cnt=0.
  - rst has priority over eop and shift_enable.
- Internal state:
  - bit_cnt: 0..DATA_WIDTH-1, count of accepted bits in the current word, width $clog2(DATA_WIDTH).
  - ones_cnt: 0..STUFF_RUN, count of consecutive accepted ones.
- Priority at each edge, highest first: rst > eop > shift_enable > hold.
- eop=1:
  - bit_cnt <= 0, ones_cnt <= 0, stuff_error <= 0.
  - partial_byte <= 1 for one cycle iff bit_cnt != 0 before the edge.
  - rx_data is retained; any coincident shift_enable sample is dropped.
- shift_enable=1 with ones_cnt == STUFF_RUN (stuff slot):
  - Sample is discarded: no shift, bit_cnt unchanged.
  - d_original=0: ones_cnt <= 0.
  - d_original=1: violation; see Optional Feature.
- shift_enable=1 with ones_cnt < STUFF_RUN (data slot):
  - rx_data <= {d_original, rx_data[DATA_WIDTH-1:1]}.
  - ones_cnt <= d_original ? ones_cnt+1 : 0.
  - If bit_cnt == DATA_WIDTH-1: bit_cnt <= 0 (wrap) and byte_received <= 1 for the next cycle. Otherwise bit_cnt <= bit_cnt+1.
- Latency: byte_received is high exactly the cycle after the edge that accepts the last bit. rx_data is valid that same cycle and stays stable until the next accepted bit.
- ones_cnt is not cleared at word boundaries; a run of ones may span two words.
- Minimum strobe spacing: back-to-back shift_enable on consecutive cycles is legal, so words may complete every DATA_WIDTH cycles.
- shift_enable=0 and eop=0: all state holds. byte_received and partial_byte return to 0 (pulse outputs, never held).

Optional Feature:
- Macro: RX_STUFF_ERR_EN.
- Defined:
  - A 1 in the stuff slot sets stuff_error <= 1 (sticky until eop or rst).
  - The bit is discarded and ones_cnt stays at STUFF_RUN, so every further 1 is also discarded until a 0 arrives.
- Undefined:
  - stuff_error is tied to 0.
  - A 1 in the stuff slot is discarded and ones_cnt <= 0 (resynchronise silently).

Test Plan:
- Bits 1,0,1,0,0,1,0,1 on 8 strobes, with 3 idle cycles between strobes -> one byte_received pulse one cycle after the 8th strobe, rx_data=8'hA5. No pulse earlier; stuff_error=0.
- Bits 1,1,1,1,1,1,0(stuff),1,1 -> stuff bit dropped, byte_received after the 9th strobe, rx_data=8'hFF. Then bits 0x00 LSB-first -> rx_data=8'h00 with no extra drops.
- Seven consecutive 1s with RX_STUFF_ERR_EN defined -> stuff_error=1 after the 7th strobe and held. Then eop -> stuff_error=0 next cycle. Same stimulus with the macro undefined -> stuff_error stays 0.
- 3 bits accepted, then eop together with a shift_enable -> partial_byte pulses once, coincident bit is ignored. The next 8 bits 0x3C -> rx_data=8'h3C, proving alignment restarted.
- Back-to-back strobes, 16 bits 0x12 then 0x34 -> byte_received pulses exactly 8 cycles apart, with rx_data 8'h12 then 8'h34.
- rst asserted after 5 accepted bits -> next cycle rx_data=0 and all flags 0. The following 8 bits 0x81 -> rx_data=8'h81.
